// File: rtl/systolic_skew_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Purpose  : Holds operand matrices A and B for an N x N systolic array and
//            streams them into the array edges with diagonal skew. Row i of A
//            enters the left edge delayed by i steps. Column j of B enters the
//            top edge delayed by j steps. Zeros pad both ends of each lane.
//            Also issues an accumulator-clear strobe ahead of the stream and a
//            completion pulse on the cycle after the last PE update.
// Ports    : clock, reset_n    - clock, async active-low reset
//            wr_en/wr_sel/wr_row/wr_col/wr_data - operand load (IDLE only)
//            start             - begin a pass (sampled in IDLE)
//            busy, acc_clr     - pass active, one-cycle accumulator clear
//            a_out, b_out      - left / top edge feeds, lane i at [W*i +: W]
//            done              - one-cycle pulse when all PE results are final
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           wr_en,
  input  logic           wr_sel,
  input  logic [1:0]     wr_row,
  input  logic [1:0]     wr_col,
  input  logic [W-1:0]   wr_data,
  input  logic           start,
  output logic           busy,
  output logic           acc_clr,
  output logic [N*W-1:0] a_out,
  output logic [N*W-1:0] b_out,
  output logic           done
);

  localparam int              C_LAST   = 3*N - 3;
  localparam int              C_TW     = $clog2(C_LAST + 1);
  localparam int              C_IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [C_TW-1:0] C_T_LAST = C_TW'(C_LAST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [C_TW-1:0]   r_t;
  logic [C_TW-1:0]   w_t_nxt;
  logic [W-1:0]      r_bank_a [N][N];
  logic [W-1:0]      r_bank_b [N][N];
  logic              w_wr_fire;
  logic [N*W-1:0]    w_a_nxt;
  logic [N*W-1:0]    w_b_nxt;

  // Loads are accepted only while idle and only for in-range coordinates.
  assign w_wr_fire = wr_en && (r_state == S_IDLE) &&
                     (int'(wr_row) < N) && (int'(wr_col) < N);

  // --------------------------------------------------------------------------
  // State / step-counter register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_t_nxt     = '0;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (r_t == C_T_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Feed selection for the upcoming cycle. Computed from next state/step so
  // the edge feeds can be registered and still line up with the step they
  // belong to. Banks are frozen outside IDLE, so reading them one cycle early
  // is safe; a write coinciding with start lands before the first STREAM read.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    if (w_state_nxt == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(w_t_nxt) >= i) && (int'(w_t_nxt) - i < N)) begin
          w_a_nxt[W*i +: W] = r_bank_a[C_IW'(i)][C_IW'(int'(w_t_nxt) - i)];
          w_b_nxt[W*i +: W] = r_bank_b[C_IW'(int'(w_t_nxt) - i)][C_IW'(i)];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operand banks
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_bank_a[r][c] <= '0;
          r_bank_b[r][c] <= '0;
        end
      end
    end else if (w_wr_fire) begin
      if (wr_sel) begin
        r_bank_b[C_IW'(wr_row)][C_IW'(wr_col)] <= wr_data;
      end else begin
        r_bank_a[C_IW'(wr_row)][C_IW'(wr_col)] <= wr_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs: no combinational path from any input to any output.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      acc_clr <= 1'b0;
      done    <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
    end else begin
      busy    <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_STREAM);
      acc_clr <= (w_state_nxt == S_CLEAR);
      done    <= (w_state_nxt == S_DONE);
      a_out   <= w_a_nxt;
      b_out   <= w_b_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Purpose  : Scoreboard bench for systolic_skew_feeder. Stimulus pushes one
//            expected record per active output cycle; a monitor pops and
//            compares whenever busy/acc_clr/done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int NS = 3*N - 2;

  logic           clock   = 1'b0;
  logic           reset_n = 1'b0;
  logic           wr_en   = 1'b0;
  logic           wr_sel  = 1'b0;
  logic [1:0]     wr_row  = '0;
  logic [1:0]     wr_col  = '0;
  logic [W-1:0]   wr_data = '0;
  logic           start   = 1'b0;
  logic           busy;
  logic           acc_clr;
  logic           done;
  logic [N*W-1:0] a_out;
  logic [N*W-1:0] b_out;

  systolic_skew_feeder #(.N(N), .W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .acc_clr (acc_clr),
    .a_out   (a_out),
    .b_out   (b_out),
    .done    (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic           busy;
    logic           clr;
    logic           done;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    int             step;
  } exp_t;

  exp_t           exp_q[$];
  int             checks   = 0;
  int             failures = 0;
  logic [W-1:0]   ma [N][N];
  logic [W-1:0]   mb [N][N];
  logic [N*W-1:0] cap_a [NS];
  logic [N*W-1:0] cap_b [NS];
  bit             model_idle = 1'b1;

  task automatic chk(input string name, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference pass: CLEAR record, NS stream steps, DONE record.
  task automatic push_pass();
    exp_t e;
    e.busy = 1'b1; e.clr = 1'b1; e.done = 1'b0;
    e.a = '0; e.b = '0; e.step = -1;
    exp_q.push_back(e);
    for (int t = 0; t < NS; t++) begin
      e.clr = 1'b0; e.a = '0; e.b = '0; e.step = t;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          e.a[W*i +: W] = ma[i][t-i];
          e.b[W*i +: W] = mb[t-i][i];
        end
      end
      exp_q.push_back(e);
    end
    e.busy = 1'b0; e.done = 1'b1; e.a = '0; e.b = '0; e.step = NS;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (busy || acc_clr || done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_activity", {45'd0, busy, acc_clr, done}, '0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("flags_step%0d", e.step),
                {45'd0, busy, acc_clr, done}, {45'd0, e.busy, e.clr, e.done});
            chk($sformatf("a_out_step%0d", e.step), a_out, e.a);
            chk($sformatf("b_out_step%0d", e.step), b_out, e.b);
            if (e.step >= 0 && e.step < NS) begin
              cap_a[e.step] = a_out;
              cap_b[e.step] = b_out;
            end
          end
        end else begin
          chk("idle_feeds", a_out | b_out, '0);
        end
      end
    end
  end

  task automatic wr(input bit sel, input int r, input int c,
                    input logic [W-1:0] d, input bit with_start);
    @(negedge clock);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c);
    wr_data = d; start = with_start;
    if (model_idle && r < N && c < N) begin
      if (sel) mb[r][c] = d;
      else     ma[r][c] = d;
    end
    if (with_start && model_idle) begin
      push_pass();
      model_idle = 1'b0;
    end
    @(negedge clock);
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic start_pass();
    @(negedge clock);
    start = 1'b1;
    push_pass();
    model_idle = 1'b0;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_pass(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_complete"}, 48'(exp_q.size()), '0);
    exp_q.delete();
    model_idle = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_flags", {45'd0, busy, acc_clr, done}, '0);
    chk("reset_a_out", a_out, '0);
    chk("reset_b_out", b_out, '0);
    reset_n = 1'b1;

    // Skew pattern load plus an out-of-range write that must be dropped
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        wr(1'b0, i, k, W'(16'h0100 * (3*i + k + 1)), 1'b0);
        wr(1'b1, i, k, W'(16'h1000 + 3*i + k), 1'b0);
      end
    wr(1'b0, 3, 0, 16'hDEAD, 1'b0);
    wr(1'b1, 0, 3, 16'hBEEF, 1'b0);
    start_pass();
    wait_pass("skew");
    chk("skew_s0_a", cap_a[0], 48'h0000_0000_0100);
    chk("skew_s0_b", cap_b[0], 48'h0000_0000_1000);
    chk("skew_s2_a2", 48'(cap_a[2][47:32]), 48'h0700);
    chk("skew_s2_b2", 48'(cap_b[2][47:32]), 48'h1002);
    chk("skew_s4_a", cap_a[4], 48'h0900_0000_0000);
    chk("skew_s4_b", cap_b[4], 48'h1008_0000_0000);
    chk("skew_s6_a", cap_a[6], '0);
    chk("skew_s6_b", cap_b[6], '0);

    // Busy lockout: write + start during STREAM must be ignored
    start_pass();
    repeat (3) @(negedge clock);
    wr(1'b0, 0, 0, 16'hFFFF, 1'b1);
    wait_pass("lockout");
    repeat (12) @(negedge clock);
    start_pass();
    wait_pass("after_lockout");
    chk("old_a00", 48'(cap_a[0][15:0]), 48'h0100);

    // Identity A, B all 2.0
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        wr(1'b0, i, k, (i == k) ? 16'h3C00 : 16'h0000, 1'b0);
        wr(1'b1, i, k, 16'h4000, 1'b0);
      end
    start_pass();
    wait_pass("identity");
    chk("ident_s4_a", cap_a[4], 48'h3C00_0000_0000);
    chk("ident_s2_b", cap_b[2], 48'h4000_4000_4000);

    // Same-cycle write + start
    wr(1'b0, 1, 1, 16'h3555, 1'b1);
    wait_pass("wr_start");
    chk("wr_start_s2_a1", 48'(cap_a[2][31:16]), 48'h3555);

    // Reset mid-pass at step 3
    start_pass();
    repeat (4) @(negedge clock);
    chk("pre_reset_busy", {47'd0, busy}, 48'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_flags", {45'd0, busy, acc_clr, done}, '0);
    chk("midreset_a_out", a_out, '0);
    chk("midreset_b_out", b_out, '0);
    exp_q.delete();
    model_idle = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_idle", {45'd0, busy, acc_clr, done}, '0);
    start_pass();
    wait_pass("zero_pass");
    chk("zero_s2_a", cap_a[2], '0);
    chk("zero_s2_b", cap_b[2], '0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
